// File: rtl/ls_err_cnt_mc_if.sv
// ls_err_cnt_mc_if: host/test-chip signal bundle for the multi-channel error counter
interface ls_err_cnt_mc_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 16,
    parameter int LAT_W = 4,
    parameter int SEL_W = 3
);
    logic             en_i;
    logic             clr_i;
    logic [LAT_W-1:0] lat_i;
    logic [N_CH-1:0]  q_i;
    logic [N_CH-1:0]  data_i;
    logic             snap_i;
    logic [SEL_W-1:0] rd_sel_i;
    logic [CNT_W-1:0] rd_cnt_o;
    logic [N_CH-1:0]  sat_o;
    logic             err_any_o;
    logic             busy_o;
    modport master (
        output en_i, clr_i, lat_i, q_i, data_i, snap_i, rd_sel_i,
        input  rd_cnt_o, sat_o, err_any_o, busy_o
    );
    modport slave (
        input  en_i, clr_i, lat_i, q_i, data_i, snap_i, rd_sel_i,
        output rd_cnt_o, sat_o, err_any_o, busy_o
    );
endinterface

// File: rtl/ls_err_cnt_mc.sv
// ls_err_cnt_mc: per-channel Q vs delayed DATA error counter with saturation, snapshot and readout
module ls_err_cnt_mc #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 16,
    parameter int LAT_W = 4,
    parameter int SEL_W = 3
) (
    input logic            CLK,
    input logic            RST,
    ls_err_cnt_mc_if.slave bus
);
    localparam int IW    = $clog2(N_CH);
    localparam int DEPTH = 2 ** LAT_W;
    localparam logic [LAT_W:0]   ONE   = 1;
    localparam logic [CNT_W-1:0] MAXM1 = {{(CNT_W-1){1'b1}}, 1'b0};
    typedef enum logic [1:0] {IDLE, FILL, COUNT} state_t;
    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W:0]   fill_q, fill_d;
    logic [N_CH-1:0]  q_q, mis, inc, sat_q, sat_d;
    logic [N_CH-1:0]  dl_q [DEPTH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] shd_q [N_CH];
    logic [CNT_W-1:0] rd_q, rd_d;
    logic             err_q, err_d;

    // FILL lasts lat_q+1 cycles so the delay line holds only in-session DATA
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: if (bus.en_i) begin
                state_d = FILL;
                lat_d   = bus.lat_i;
                fill_d  = {1'b0, bus.lat_i} + ONE;
            end
            FILL: begin
                fill_d  = fill_q - ONE;
                state_d = !bus.en_i ? IDLE : (fill_q == ONE) ? COUNT : FILL;
            end
            COUNT: state_d = bus.en_i ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mis = q_q ^ dl_q[lat_q];

    always_comb begin
        inc   = '0;
        sat_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            inc[i]   = state_q == COUNT && mis[i] && cnt_q[i] != '1;
            cnt_d[i] = bus.clr_i ? '0 : cnt_q[i] + CNT_W'(inc[i]);
            sat_d[i] = !bus.clr_i && (sat_q[i] || (inc[i] && cnt_q[i] == MAXM1));
        end
        err_d = !bus.clr_i && (err_q || (|inc));
        rd_d  = 32'(bus.rd_sel_i) < N_CH ? shd_q[bus.rd_sel_i[IW-1:0]] : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            lat_q   <= '0;
            fill_q  <= '0;
            q_q     <= '0;
            sat_q   <= '0;
            err_q   <= '0;
            rd_q    <= '0;
            dl_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
            shd_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            fill_q  <= fill_d;
            q_q     <= bus.q_i;
            sat_q   <= sat_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            dl_q[0] <= bus.data_i;
            for (int k = 1; k < DEPTH; k++) dl_q[k] <= dl_q[k-1];
            cnt_q   <= cnt_d;
            if (bus.snap_i) shd_q <= cnt_q;
        end
    end

    assign bus.rd_cnt_o  = rd_q;
    assign bus.sat_o     = sat_q;
    assign bus.err_any_o = err_q;
    assign bus.busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_ls_err_cnt_mc.sv
// tb_ls_err_cnt_mc: table, directed and random checks of ls_err_cnt_mc against a history-based model
module tb_ls_err_cnt_mc;
    localparam int N = 8, CW = 4, LW = 4, SW = 4, MAX = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, bad = 0;

    ls_err_cnt_mc_if #(.N_CH(N), .CNT_W(CW), .LAT_W(LW), .SEL_W(SW)) bus ();
    ls_err_cnt_mc #(.N_CH(N), .CNT_W(CW), .LAT_W(LW), .SEL_W(SW)) dut (
        .CLK(clk), .RST(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // model: phase -1 idle, >0 fill cycles left, 0 counting; history of DATA by age
    int       m_phase, m_lat, m_rd;
    int       m_cnt [N];
    int       m_shd [N];
    bit [N-1:0] m_sat, m_qr;
    bit         m_err;
    bit [N-1:0] m_hist [16];

    typedef struct {
        bit en, clr, snap;
        bit [3:0] lat, sel;
        bit [7:0] q, data;
        bit busy, err;
        int rd;
    } vec_t;
    vec_t tbl [13];

    function automatic void model_reset();
        m_phase = -1; m_lat = 0; m_rd = 0; m_sat = '0; m_qr = '0; m_err = 1'b0;
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_shd[i] = 0; end
        for (int k = 0; k < 16; k++) m_hist[k] = '0;
    endfunction

    function automatic void model_step(bit en, bit clr, bit snap, bit [3:0] lat, bit [3:0] sel,
                                       bit [7:0] q, bit [7:0] data);
        bit [N-1:0] mis = m_qr ^ m_hist[m_lat];
        int old [N] = m_cnt;
        m_rd = (sel < N) ? m_shd[sel] : 0;
        for (int i = 0; i < N; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (m_phase == 0 && mis[i] && m_cnt[i] < MAX) begin
                m_cnt[i]++;
                m_err = 1'b1;
                if (m_cnt[i] == MAX) m_sat[i] = 1'b1;
            end
        end
        if (clr) begin m_sat = '0; m_err = 1'b0; end
        if (snap) m_shd = old;
        if (m_phase < 0) begin
            if (en) begin m_phase = int'(lat) + 1; m_lat = int'(lat); end
        end else if (!en) m_phase = -1;
        else if (m_phase > 0) m_phase--;
        for (int k = 15; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = data;
        m_qr = q;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rd_cnt", int'(bus.rd_cnt_o), m_rd);
        chk("sat", int'(bus.sat_o), int'(m_sat));
        chk("err_any", int'(bus.err_any_o), int'(m_err));
        chk("busy", int'(bus.busy_o), int'(m_phase >= 0));
    endtask

    task automatic cyc(bit en, bit clr, bit snap, bit [3:0] lat, bit [3:0] sel, bit [7:0] q, bit [7:0] data);
        bus.en_i = en; bus.clr_i = clr; bus.snap_i = snap; bus.lat_i = lat;
        bus.rd_sel_i = sel; bus.q_i = q; bus.data_i = data;
        @(posedge clk);
        model_step(en, clr, snap, lat, sel, q, data);
        #1;
        check_all();
    endtask

    task automatic read_ch(bit [3:0] ch, output int v);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, ch, 8'h00, 8'h00);
        v = int'(bus.rd_cnt_o);
    endtask

    initial begin
        bit [7:0] d, past [3];
        int v, n;
        bus.en_i = 0; bus.clr_i = 0; bus.snap_i = 0; bus.lat_i = 0;
        bus.rd_sel_i = 0; bus.q_i = 0; bus.data_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        // aligned random traffic never counts
        for (int t = 0; t < 1000; t++) begin
            d = 8'($urandom);
            cyc(1'b1, 1'b0, $urandom_range(0, 3) == 0, 4'd0, 4'($urandom_range(0, 9)), d, d);
        end
        chk("t1_err_any", int'(bus.err_any_o), 0);
        chk("t1_sat", int'(bus.sat_o), 0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        // LAT=5 fill window with ch0 permanently mismatching
        for (int r = 0; r < 7; r++) tbl[r] = '{1, 0, 0, 5, 0, 8'h01, 8'h00, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 5, 0, 8'h01, 8'h00, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 8'h01, 8'h00, 0, 1, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 2};
        tbl[11] = '{0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 2};
        for (int r = 0; r < 13; r++) begin
            cyc(tbl[r].en, tbl[r].clr, tbl[r].snap, tbl[r].lat, tbl[r].sel, tbl[r].q, tbl[r].data);
            chk($sformatf("tbl%0d_busy", r), int'(bus.busy_o), int'(tbl[r].busy));
            chk($sformatf("tbl%0d_err", r), int'(bus.err_any_o), int'(tbl[r].err));
            chk($sformatf("tbl%0d_rd", r), int'(bus.rd_cnt_o), tbl[r].rd);
        end
        // Q is DATA delayed 3 cycles: LAT=3 aligns, LAT=2 counts ch transitions
        for (int pass = 0; pass < 2; pass++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
            past = '{default: 8'h00};
            for (int t = 0; t < 30; t++) begin
                d = 8'($urandom) & 8'h04;
                cyc(1'b1, 1'b0, 1'b0, pass == 0 ? 4'd3 : 4'd2, 4'd0, past[2], d);
                past[2] = past[1]; past[1] = past[0]; past[0] = d;
            end
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
            read_ch(4'd2, v);
            if (pass == 0) chk("t2_aligned_cnt2", v, 0);
            else chk("t2_skew_cnt2", v, m_cnt[2]);
        end
        // saturation on ch0
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        for (int t = 0; t < 22; t++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h01, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        read_ch(4'd0, v);
        chk("t4_cnt0_sat", v, 15);
        chk("t4_sat_bits", int'(bus.sat_o), 1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        chk("t4_sat_clr", int'(bus.sat_o), 0);
        read_ch(4'd0, v);
        chk("t4_cnt0_clr", v, 0);
        // snapshot coincident with an increment on ch1
        n = 0;
        while (m_cnt[1] != 6 && n < 20) begin cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h02, 8'h00); n++; end
        chk("t5_reach6", m_cnt[1], 6);
        cyc(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 8'h02, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 8'h00, 8'h00);
        chk("t5_snap_pre_inc", int'(bus.rd_cnt_o), 6);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 8'h00, 8'h00);
        chk("t5_sel_oob", int'(bus.rd_cnt_o), 0);
        // async reset mid-session
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        n = 0;
        while (m_cnt[3] != 9 && n < 20) begin cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h08, 8'h00); n++; end
        chk("t6_reach9", m_cnt[3], 9);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_busy_rst", int'(bus.busy_o), 0);
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 8'h08, 8'h00);
        chk("t6_busy_rearm", int'(bus.busy_o), 1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 8'h08, 8'h00);
        chk("t6_cnt3_reset", int'(bus.rd_cnt_o), 0);
        // random mix of sessions, clears, snapshots and readouts
        for (int t = 0; t < 600; t++) begin
            d = 8'($urandom);
            cyc($urandom_range(0, 15) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0,
                4'($urandom), 4'($urandom_range(0, 9)),
                d ^ (8'($urandom) & 8'($urandom) & 8'($urandom)), d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
